vr_sample_align: RTL and testbench
==================================

VR_SAMPLE_ALIGN -- requirements
Module: vr_sample_align

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of input channels (1..16).
REQ-002 SHALL have parameter DW, default 16, signed sample width per channel.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024, collection timeout in clk cycles (≥2); used only with the timeout feature.
REQ-004 SHALL have ports: clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have: ch_en  in  N_CH  per-channel gating enable; 1 = channel must arrive before output.
REQ-007 SHALL have: in_data  in  N_CH*DW  packed samples, channel i at bits [i*DW +: DW].
REQ-008 SHALL have: in_valid  in  N_CH  per-channel valid.
REQ-009 SHALL have: in_ready  out  N_CH  per-channel ready.
REQ-010 SHALL have: out_data  out  N_CH*DW  aligned sample frame, same packing.
REQ-011 SHALL have: out_valid  out  1  frame valid.
REQ-012 SHALL have: out_ready  in  1  downstream ready.
REQ-013 SHALL have: out_stale  out  N_CH  per-channel flag: slot holds a previous value, not a fresh capture.

Function
REQ-014 SHALL hold per channel a DW-bit hold register and a fresh flag; transfer on channel i occurs when in_valid[i] && in_ready[i].
REQ-015 SHALL implement FSM states COLLECT and PRESENT; reset state COLLECT.
REQ-016 In COLLECT, in_ready[i] SHALL be !fresh[i] for enabled channels and 1 for disabled channels.
REQ-017 A transfer SHALL write the hold register and set fresh[i]; on disabled channels, it SHALL overwrite the hold register only and leave fresh[i] at 0.
REQ-018 COLLECT→PRESENT SHALL occur when ch_en != 0 and every enabled channel is fresh, counting transfers in the current cycle; out_valid SHALL rise on the next cycle (1-cycle latency from the last required transfer).
REQ-019 On the transition, SHALL snapshot all hold registers (including the current cycle's transfers) into out_data and set out_stale[i] = !fresh_next[i].
REQ-020 In PRESENT, out_valid=1, and out_data/out_stale SHALL stay stable; in_ready SHALL be 0 for enabled channels and 1 for disabled channels (hold registers keep updating; snapshot unaffected).
REQ-021 In PRESENT, when out_ready=1, SHALL clear all fresh flags and return to COLLECT; out_valid falls on the next cycle.
REQ-022 With ch_en == 0, SHALL remain in COLLECT with out_valid=0.
REQ-023 ch_en changes SHALL take effect the cycle they are seen; clearing the last missing enabled channel completes the frame per REQ-018.
REQ-024 A fresh flag already set on a channel that becomes disabled SHALL persist until the frame is consumed.

Reset
REQ-025 While rst_n=0, SHALL force: state COLLECT, hold registers 0, fresh 0, out_data 0, out_valid 0, out_stale 0, timeout counter 0.
REQ-026 Reset asserted mid-frame SHALL discard partial captures; in_ready SHALL follow REQ-016 from the first cycle after deassertion.

Configuration
REQ-027 Macro VR_SAMPLE_ALIGN_TIMEOUT_EN SHALL compile in the timeout feature.
REQ-028 When defined, a counter SHALL start at the first fresh capture in COLLECT; if it reaches TIMEOUT_CYC-1 before completion, the next cycle SHALL enter PRESENT with the held (last) values and out_stale set for non-fresh channels.
REQ-029 When defined, the counter SHALL clear on entering PRESENT and SHALL not count while no channel is fresh.
REQ-030 When undefined, SHALL have no counter logic; COLLECT SHALL wait indefinitely, and out_stale SHALL be set only for disabled non-fresh channels.

Verification
REQ-031 N_CH=4, ch_en=4'b1111: deliver ch0..ch3 on cycles 0..3 (0x0001..0x0004) -> out_valid at cycle 4, out_data={0x0004,0x0003,0x0002,0x0001}, out_stale=0.
REQ-032 ch_en=4'b1110, ch0 sends 0x7FFF then 0x1234, ch1-3 complete -> frame ch0 slot=0x1234, out_stale=4'b0001, in_ready[0] stays 1 throughout.
REQ-033 out_ready=0 held 10 cycles in PRESENT, new in_valid on ch1 -> out_data unchanged, in_ready[1]=0; out_ready=1 -> out_valid low next cycle, ch1 accepted the cycle after.
REQ-034 All four in_valid high in the same cycle with out_ready=1 constantly -> one frame per 2 cycles, no sample lost or duplicated over 100 frames.
REQ-035 With VR_SAMPLE_ALIGN_TIMEOUT_EN, TIMEOUT_CYC=8: only ch0-2 deliver -> out_valid 8 cycles after first capture, out_stale=4'b1000, ch3 slot=prior value.
REQ-036 rst_n pulsed low mid-COLLECT with ch0,ch1 fresh -> all outputs 0; a fresh full frame afterwards completes with out_stale=0.

Source files
------------

// File: rtl/vr_sample_align_if.sv
// Handshake bundle for vr_sample_align: per-channel sample inputs with
// valid/ready, and one aligned output frame with valid/ready and stale flags.
// The source/sink side uses the master modport; the aligner uses slave.
interface vr_sample_align_if #(
  parameter int N_CH = 4,
  parameter int DW   = 16
);
  logic [N_CH-1:0]    ch_en;
  logic [N_CH*DW-1:0] in_data;
  logic [N_CH-1:0]    in_valid;
  logic [N_CH-1:0]    in_ready;
  logic [N_CH*DW-1:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic [N_CH-1:0]    out_stale;

  modport master (
    output ch_en, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_stale
  );

  modport slave (
    input  ch_en, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_stale
  );
endinterface

// File: rtl/vr_sample_align.sv
// vr_sample_align: collects one sample per enabled channel into per-channel
// hold registers, then presents them together as one aligned frame.
// Disabled channels are always ready; their samples update the hold register
// but never gate frame completion, and show up flagged as stale.
// Optional feature: define VR_SAMPLE_ALIGN_TIMEOUT_EN to force a frame out
// TIMEOUT_CYC cycles after the first capture even if channels are missing.
module vr_sample_align #(
  parameter int N_CH        = 4,
  parameter int DW          = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  vr_sample_align_if.slave   bus
);

  // Parameter range guard, evaluated at elaboration only.
  if (N_CH < 1 || N_CH > 16 || DW < 1 || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("vr_sample_align: parameter out of range");
  end

  typedef enum logic {COLLECT = 1'b0, PRESENT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [N_CH-1:0]    fresh_q, fresh_d;
  logic [N_CH*DW-1:0] out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic [N_CH-1:0]    out_stale_q, out_stale_d;

  logic [N_CH-1:0]    in_ready_c;
  logic [N_CH-1:0]    xfer;
  logic [N_CH*DW-1:0] hold_next_flat;
  logic               all_fresh;
  logic               tmo_hit;

  // Per-channel ready, transfer detect and hold register.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [DW-1:0] hold_q, hold_d;

    // Enabled channels take one sample per frame and stall while presenting;
    // disabled channels are never back-pressured.
    assign in_ready_c[gi] = bus.ch_en[gi] ? ((state_q == COLLECT) && !fresh_q[gi]) : 1'b1;
    assign xfer[gi]       = bus.in_valid[gi] && in_ready_c[gi];

    // Hold register captures every accepted sample, in either state.
    always_comb begin
      hold_d = hold_q;
      if (xfer[gi]) hold_d = bus.in_data[gi*DW +: DW];
    end

    // Hold register state.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hold_q <= '0;
      else        hold_q <= hold_d;
    end

    // Snapshot source includes this cycle's captures.
    assign hold_next_flat[gi*DW +: DW] = hold_d;
  end

  // Fresh flags: set by enabled captures while collecting, cleared when the
  // frame is consumed. A flag on a channel that gets disabled just persists.
  always_comb begin
    fresh_d = fresh_q;
    if (state_q == COLLECT) begin
      fresh_d = fresh_q | (xfer & bus.ch_en);
    end else if (bus.out_ready) begin
      fresh_d = '0;
    end
  end

  assign all_fresh = (bus.ch_en != '0) && ((fresh_d & bus.ch_en) == bus.ch_en);

`ifdef VR_SAMPLE_ALIGN_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tmo_hit = (state_q == COLLECT) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Timeout counter: runs from the first capture of a frame (the capture
  // cycle itself counts), idles while nothing is fresh, clears on completion.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != COLLECT || all_fresh || tmo_hit) begin
      cnt_d = '0;
    end else if (|fresh_d) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Timeout counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Frame FSM next-state and output snapshot.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_stale_d = out_stale_q;
    case (state_q)
      COLLECT: begin
        if (all_fresh || tmo_hit) begin
          state_d     = PRESENT;
          out_data_d  = hold_next_flat;
          out_valid_d = 1'b1;
          out_stale_d = ~fresh_d;
        end
      end
      PRESENT: begin
        if (bus.out_ready) begin
          state_d     = COLLECT;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = COLLECT;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Frame FSM and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      fresh_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_stale_q <= '0;
    end else begin
      state_q     <= state_d;
      fresh_q     <= fresh_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_stale_q <= out_stale_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_stale = out_stale_q;

endmodule

// File: tb/tb_vr_sample_align.sv
// Scoreboard bench for vr_sample_align (N_CH=4, DW=16, TIMEOUT_CYC=8).
// Expected frames are queued as stimulus is driven and checked when the
// output handshake completes. Timeout scenario depends on
// VR_SAMPLE_ALIGN_TIMEOUT_EN.
module tb_vr_sample_align;
  localparam int N_CH = 4;
  localparam int DW   = 16;
  localparam int TMO  = 8;

  typedef struct packed {
    logic [N_CH*DW-1:0] data;
    logic [N_CH-1:0]    stale;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vr_sample_align_if #(.N_CH(N_CH), .DW(DW)) bus ();

  vr_sample_align #(.N_CH(N_CH), .DW(DW), .TIMEOUT_CYC(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  frame_t             exp_q[$];
  int                 n_checks = 0;
  int                 n_errors = 0;
  int                 n_frames = 0;
  int                 n_pushed = 0;
  logic [N_CH*DW-1:0] model_hold = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model hold contents after a transfer on the channels in mask.
  function automatic logic [63:0] merge(input logic [3:0] mask, input logic [63:0] d);
    logic [63:0] r;
    r = model_hold;
    for (int i = 0; i < N_CH; i++) if (mask[i]) r[i*DW +: DW] = d[i*DW +: DW];
    return r;
  endfunction

  task automatic push_frame(input logic [63:0] d, input logic [3:0] stale);
    frame_t f;
    f.data  = d;
    f.stale = stale;
    exp_q.push_back(f);
    n_pushed++;
  endtask

  // One-cycle transfer on the channels in mask; they must be ready.
  task automatic send(input logic [3:0] mask, input logic [63:0] d);
    bus.in_data  = d;
    bus.in_valid = mask;
    @(negedge clk);
    check_val("send_ready", 64'(bus.in_ready & mask), 64'(mask));
    @(posedge clk);
    #1;
    bus.in_valid = '0;
    model_hold   = merge(mask, d);
  endtask

  task automatic consume();
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  // Output monitor: compare every accepted frame against the scoreboard.
  always @(negedge clk) begin
    frame_t f;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check_val("frame_unexpected", 64'd1, 64'd0);
      end else begin
        f = exp_q.pop_front();
        check_val("frame_data", bus.out_data, f.data);
        check_val("frame_stale", 64'(bus.out_stale), 64'(f.stale));
        $display("frame %0d data=0x%016h stale=%b", n_frames, bus.out_data, bus.out_stale);
        n_frames++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    int          waits;
    int          k;
    bit          seen;

    bus.ch_en     = 4'hF;
    bus.in_data   = '0;
    bus.in_valid  = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("rst_out_data", bus.out_data, 64'd0);
    check_val("rst_out_stale", 64'(bus.out_stale), 64'd0);
    check_val("rst_in_ready", 64'(bus.in_ready), 64'hF);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // ch_en == 0: disabled transfers only, no frame
    bus.ch_en = '0;
    send(4'hF, 64'hDDDD_CCCC_BBBB_AAAA);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check_val("en0_no_frame", 64'(seen), 64'd0);
    @(posedge clk);
    #1 bus.ch_en = 4'hF;
    @(negedge clk);
    check_val("en0_not_fresh", 64'(bus.in_ready), 64'hF);

    // Basic frame, ch0..ch3 on consecutive cycles
    @(posedge clk);
    #1;
    send(4'b0001, 64'h0000_0000_0000_0001);
    send(4'b0010, 64'h0000_0000_0002_0000);
    send(4'b0100, 64'h0000_0003_0000_0000);
    check_val("t1_not_early", 64'(bus.out_valid), 64'd0);
    push_frame(64'h0004_0003_0002_0001, 4'b0000);
    send(4'b1000, 64'h0004_0000_0000_0000);
    @(negedge clk);
    check_val("t1_latency", 64'(bus.out_valid), 64'd1);

    // Stall in PRESENT with new data pending on ch1
    bus.in_data  = 64'h0000_0000_BEEF_0000;
    bus.in_valid = 4'b0010;
    repeat (10) begin
      @(negedge clk);
      check_val("t1_hold_data", bus.out_data, 64'h0004_0003_0002_0001);
      check_val("t1_hold_ready1", 64'(bus.in_ready[1]), 64'd0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check_val("t1_valid_fall", 64'(bus.out_valid), 64'd0);
    check_val("t1_ready1_back", 64'(bus.in_ready[1]), 64'd1);
    @(posedge clk);
    #1 bus.in_valid = '0;
    model_hold = merge(4'b0010, 64'h0000_0000_BEEF_0000);
    @(negedge clk);
    check_val("t1_ch1_fresh", 64'(bus.in_ready), 64'(4'b1101));
    @(posedge clk);
    #1;
    d = 64'h0033_0022_0000_0011;
    push_frame(merge(4'b1101, d), 4'b0000);
    send(4'b1101, d);
    @(negedge clk);
    check_val("t1b_valid", 64'(bus.out_valid), 64'd1);
    consume();

    // Disabled ch0 sends twice, last value wins, flagged stale
    bus.ch_en = 4'b1110;
    send(4'b0001, 64'h0000_0000_0000_7FFF);
    send(4'b0011, 64'h0000_0000_00A1_1234);
    d = 64'h00A3_00A2_0000_0000;
    push_frame(merge(4'b1100, d), 4'b0001);
    send(4'b1100, d);
    @(negedge clk);
    check_val("t2_valid", 64'(bus.out_valid), 64'd1);
    check_val("t2_ready_present", 64'(bus.in_ready), 64'(4'b0001));
    consume();

    // Reset mid-collect with ch0, ch1 fresh
    bus.ch_en = 4'hF;
    send(4'b0011, 64'h0000_0000_5151_5050);
    @(negedge clk);
    check_val("t3_partial", 64'(bus.in_ready), 64'(4'b1100));
    rst_n = 1'b0;
    #1;
    check_val("t3_rst_valid", 64'(bus.out_valid), 64'd0);
    check_val("t3_rst_data", bus.out_data, 64'd0);
    check_val("t3_rst_stale", 64'(bus.out_stale), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_hold = '0;
    @(negedge clk);
    check_val("t3_ready_after", 64'(bus.in_ready), 64'hF);
    @(posedge clk);
    #1;
    d = 64'h9004_9003_9002_9001;
    push_frame(merge(4'hF, d), 4'b0000);
    send(4'hF, d);
    @(negedge clk);
    check_val("t3_valid", 64'(bus.out_valid), 64'd1);
    consume();

    // Back-to-back frames with out_ready held high
    bus.out_ready = 1'b1;
    for (int f = 0; f < 100; f++) begin
      d = {$urandom(), $urandom()};
      bus.in_data  = d;
      bus.in_valid = 4'hF;
      push_frame(d, 4'b0000);
      waits = 0;
      for (int w = 0; w < 8; w++) begin
        @(negedge clk);
        waits++;
        if (bus.in_ready == 4'hF) break;
      end
      if (f > 0) check_val("t4_frame_period", 64'(waits), 64'd2);
      @(posedge clk);
      #1;
      model_hold = d;
    end
    bus.in_valid = '0;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;

    // ch3 never delivers
    d = 64'h0000_0C22_0C11_0C00;
`ifdef VR_SAMPLE_ALIGN_TIMEOUT_EN
    push_frame(merge(4'b0111, d), 4'b1000);
    send(4'b0001, d);
    send(4'b0010, d);
    send(4'b0100, d);
    seen = 1'b0;
    for (k = 3; k < 30; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check_val("t5_timeout_latency", 64'(k), 64'd8);
    consume();
`else
    send(4'b0001, d);
    send(4'b0010, d);
    send(4'b0100, d);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check_val("t5_waits", 64'(seen), 64'd0);
    @(posedge clk);
    #1;
    d = 64'h0C33_0000_0000_0000;
    push_frame(merge(4'b1000, d), 4'b0000);
    send(4'b1000, d);
    @(negedge clk);
    check_val("t5_valid", 64'(bus.out_valid), 64'd1);
    consume();
`endif

    repeat (2) @(posedge clk);
    check_val("queue_drain", 64'(exp_q.size()), 64'd0);
    check_val("frame_count", 64'(n_frames), 64'(n_pushed));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
